rx_word_deserializer: RTL and testbench

//  Parametrised successor of the 8-bit RX deserializer. Assembles a frame of

---
 rtl/uart_pkg.sv | 12 +
 rtl/rx_word_deserializer.sv | 115 +++++++++++
 tb/tb_rx_word_deserializer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    DES_IDLE,
    DES_COLLECT,
    DES_HOLD
  } des_state_t;

  localparam int unsigned UART_SYM_W = 8;

endpackage

// File: rtl/rx_word_deserializer.sv
// Assembles a LENGTH_I-bit frame from SYM_W-bit RX symbols and offers it to the
// consumer through a valid/ready handshake, with abort and length checking.
module rx_word_deserializer
  import uart_pkg::*;
#(
  parameter int unsigned  MAX_BITS  = 64,
  parameter int unsigned  SYM_W     = UART_SYM_W,
  parameter bit           MSB_FIRST = 1'b0,
  localparam int unsigned LEN_W     = $clog2(MAX_BITS + 1)
) (
  input  logic                CLK_I,
  input  logic                RST_NI,
  input  logic                START_I,
  input  logic [LEN_W-1:0]    LENGTH_I,
  input  logic                ABORT_I,
  input  logic [SYM_W-1:0]    SYM_I,
  input  logic                SYM_VALID_I,
  output logic                SYM_READY_O,
  output logic [MAX_BITS-1:0] DATA_O,
  output logic                DATA_VALID_O,
  input  logic                DATA_READY_I,
  output logic                BUSY_O,
  output logic                ERR_O
);

  // One extra bit so the running bit count never wraps past len_q.
  localparam int unsigned CNT_W = LEN_W + 1;

  des_state_t          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_next;
  logic [LEN_W-1:0]    len_q;
  logic                len_illegal;
  logic                sym_accept;
  logic                last_sym;
  logic [MAX_BITS-1:0] len_mask;
  logic [MAX_BITS-1:0] lsb_data;
  logic [MAX_BITS-1:0] msb_data;

  assign len_illegal = (LENGTH_I == '0)
                    || (CNT_W'(LENGTH_I) > CNT_W'(MAX_BITS))
                    || (MSB_FIRST && ((LENGTH_I % LEN_W'(SYM_W)) != '0));

  assign sym_accept = SYM_VALID_I && (state_q == DES_COLLECT);
  assign cnt_next   = cnt_q + CNT_W'(SYM_W);
  assign last_sym   = (cnt_next >= {1'b0, len_q});

  // Bits at or above the frame length never leave the block as ones.
  assign len_mask = ~({MAX_BITS{1'b1}} << len_q);
  assign lsb_data = (DATA_O | (MAX_BITS'(SYM_I) << cnt_q)) & len_mask;
  assign msb_data = (DATA_O << SYM_W) | MAX_BITS'(SYM_I);

  // Frame sequencing; abort wins over a same-cycle accept or handshake.
  always_ff @(posedge CLK_I or negedge RST_NI) begin : fsm
    if (!RST_NI) begin
      state_q <= DES_IDLE;
    end else begin
      case (state_q)
        DES_IDLE: begin
          if (START_I && !len_illegal) state_q <= DES_COLLECT;
        end
        DES_COLLECT: begin
          if (ABORT_I)                    state_q <= DES_IDLE;
          else if (sym_accept && last_sym) state_q <= DES_HOLD;
        end
        DES_HOLD: begin
          if (ABORT_I || DATA_READY_I) state_q <= DES_IDLE;
        end
        default: state_q <= DES_IDLE;
      endcase
    end
  end

  // Frame register, bit counter, latched length and error pulse.
  always_ff @(posedge CLK_I or negedge RST_NI) begin : datapath
    if (!RST_NI) begin
      cnt_q  <= '0;
      len_q  <= '0;
      DATA_O <= '0;
      ERR_O  <= 1'b0;
    end else begin
      ERR_O <= 1'b0;
      case (state_q)
        DES_IDLE: begin
          if (START_I) begin
            if (len_illegal) begin
              ERR_O <= 1'b1;
            end else begin
              len_q  <= LENGTH_I;
              cnt_q  <= '0;
              DATA_O <= '0;
            end
          end
        end
        DES_COLLECT: begin
          if (ABORT_I) begin
            DATA_O <= '0;
          end else if (sym_accept) begin
            DATA_O <= MSB_FIRST ? msb_data : lsb_data;
            cnt_q  <= cnt_next;
          end
        end
        DES_HOLD: begin
          if (ABORT_I) DATA_O <= '0;
        end
        default: ;
      endcase
    end
  end

  assign SYM_READY_O  = (state_q == DES_COLLECT);
  assign DATA_VALID_O = (state_q == DES_HOLD);
  assign BUSY_O       = (state_q != DES_IDLE);

endmodule

// File: tb/tb_rx_word_deserializer.sv
// Drives an LSB-first and an MSB-first deserializer with a shared stimulus and
// checks both against a frame-level reference model every cycle.
module tb_rx_word_deserializer;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [6:0]       length;
  logic             abort;
  logic [7:0]       sym;
  logic             sym_valid;
  logic             data_ready;
  logic [1:0]       sym_ready;
  logic [1:0][63:0] data_o;
  logic [1:0]       data_valid;
  logic [1:0]       busy;
  logic [1:0]       err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rx_word_deserializer #(.MAX_BITS(64), .SYM_W(8), .MSB_FIRST(1'b0)) u_lsb (
    .CLK_I(clk), .RST_NI(rst_n), .START_I(start), .LENGTH_I(length),
    .ABORT_I(abort), .SYM_I(sym), .SYM_VALID_I(sym_valid),
    .SYM_READY_O(sym_ready[0]), .DATA_O(data_o[0]), .DATA_VALID_O(data_valid[0]),
    .DATA_READY_I(data_ready), .BUSY_O(busy[0]), .ERR_O(err[0])
  );

  rx_word_deserializer #(.MAX_BITS(64), .SYM_W(8), .MSB_FIRST(1'b1)) u_msb (
    .CLK_I(clk), .RST_NI(rst_n), .START_I(start), .LENGTH_I(length),
    .ABORT_I(abort), .SYM_I(sym), .SYM_VALID_I(sym_valid),
    .SYM_READY_O(sym_ready[1]), .DATA_O(data_o[1]), .DATA_VALID_O(data_valid[1]),
    .DATA_READY_I(data_ready), .BUSY_O(busy[1]), .ERR_O(err[1])
  );

  // Reference model: phase 0 idle, 1 collecting, 2 frame offered.
  int         phase [2];
  int         mlen  [2];
  int         mcnt  [2];
  logic [7:0] msyms [2][8];
  logic       merr  [2];

  function automatic bit illegal_len(int m, int len);
    return (len == 0) || (len > 64) || ((m == 1) && (len % 8 != 0));
  endfunction

  // Expected frame contents from the symbols received so far.
  function automatic logic [63:0] exp_data(int m);
    logic [63:0] d;
    d = '0;
    for (int i = 0; i < mcnt[m]; i++) begin
      if (m == 1) d = d + (64'(msyms[m][i]) << (8 * (mcnt[m] - 1 - i)));
      else        d = d + (64'(msyms[m][i]) << (8 * i));
    end
    if (m == 0 && mlen[m] < 64) d = d & ((64'd1 << mlen[m]) - 64'd1);
    return d;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      phase[m] = 0; mlen[m] = 0; mcnt[m] = 0; merr[m] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      merr[m] = 1'b0;
      case (phase[m])
        0: if (start) begin
             if (illegal_len(m, int'(length))) merr[m] = 1'b1;
             else begin mlen[m] = int'(length); mcnt[m] = 0; phase[m] = 1; end
           end
        1: if (abort) begin mcnt[m] = 0; phase[m] = 0; end
           else if (sym_valid) begin
             msyms[m][mcnt[m]] = sym;
             mcnt[m]++;
             if (mcnt[m] * 8 >= mlen[m]) phase[m] = 2;
           end
        default: if (abort) begin mcnt[m] = 0; phase[m] = 0; end
                 else if (data_ready) phase[m] = 0;
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("data_o[%0d]", m),     data_o[m],     exp_data(m));
      chk($sformatf("data_valid[%0d]", m), data_valid[m], 64'(phase[m] == 2));
      chk($sformatf("sym_ready[%0d]", m),  sym_ready[m],  64'(phase[m] == 1));
      chk($sformatf("busy[%0d]", m),       busy[m],       64'(phase[m] != 0));
      chk($sformatf("err[%0d]", m),        err[m],        64'(merr[m]));
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s data_o[%0d]", tag, m), data_o[m], 64'd0);
      chk($sformatf("%s outs[%0d]", tag, m),
          64'({data_valid[m], sym_ready[m], busy[m], err[m]}), 64'd0);
    end
  endtask

  // One clock: model follows the edge, outputs compared 1 ns later.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    check_outputs();
  endtask

  task automatic feed(input logic [63:0] syms, input int n);
    for (int i = 0; i < n; i++) begin
      sym_valid = 1'b1;
      sym       = syms[8*i +: 8];
      tick();
    end
    sym_valid = 1'b0;
  endtask

  typedef struct packed {
    logic [6:0]  len;
    logic [63:0] syms;   // first symbol in the low byte
    logic        err0;
    logic [63:0] data0;
    logic        err1;
    logic [63:0] data1;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int budget;
    int idx;

    // 0x06 in the sixth byte lands only bit 0 (zero) at bit 40; 0xFF keeps it.
    vecs[0] = '{len: 7'd41, syms: 64'h0000_0605_0403_0201, err0: 1'b0,
                data0: 64'h0000_0005_0403_0201, err1: 1'b1, data1: 64'h0};
    vecs[1] = '{len: 7'd41, syms: 64'h0000_FF05_0403_0201, err0: 1'b0,
                data0: 64'h0000_0105_0403_0201, err1: 1'b1, data1: 64'h0};
    vecs[2] = '{len: 7'd32, syms: 64'h0000_0000_DDCC_BBAA, err0: 1'b0,
                data0: 64'h0000_0000_DDCC_BBAA, err1: 1'b0, data1: 64'h0000_0000_AABB_CCDD};
    vecs[3] = '{len: 7'd64, syms: 64'h8877_6655_4433_2211, err0: 1'b0,
                data0: 64'h8877_6655_4433_2211, err1: 1'b0, data1: 64'h1122_3344_5566_7788};
    vecs[4] = '{len: 7'd0,  syms: 64'h0, err0: 1'b1, data0: 64'h0, err1: 1'b1, data1: 64'h0};
    vecs[5] = '{len: 7'd65, syms: 64'h0, err0: 1'b1, data0: 64'h0, err1: 1'b1, data1: 64'h0};
    vecs[6] = '{len: 7'd8,  syms: 64'h5A, err0: 1'b0, data0: 64'h5A, err1: 1'b0, data1: 64'h5A};
    vecs[7] = '{len: 7'd3,  syms: 64'hFF, err0: 1'b0, data0: 64'h7, err1: 1'b1, data1: 64'h0};
    vecs[8] = '{len: 7'd16, syms: 64'h3412, err0: 1'b0, data0: 64'h3412, err1: 1'b0, data1: 64'h1234};

    rst_n = 1'b0; start = 1'b0; length = '0; abort = 1'b0;
    sym = '0; sym_valid = 1'b0; data_ready = 1'b0;
    model_reset();
    #1;
    check_all_zero("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Directed frames, each start issued right after the previous handshake.
    for (int r = 0; r < 9; r++) begin
      start  = 1'b1;
      length = vecs[r].len;
      tick();
      start = 1'b0;
      chk($sformatf("vec%0d err lsb", r), err[0], 64'(vecs[r].err0));
      chk($sformatf("vec%0d err msb", r), err[1], 64'(vecs[r].err1));
      idx = 0;
      budget = 12;
      while ((phase[0] == 1 || phase[1] == 1) && budget > 0) begin
        sym_valid = 1'b1;
        sym       = vecs[r].syms[8*idx +: 8];
        tick();
        idx++;
        budget--;
      end
      sym_valid = 1'b0;
      chk($sformatf("vec%0d collect in budget", r), 64'(budget > 0), 64'd1);
      if (!vecs[r].err0) begin
        chk($sformatf("vec%0d data lsb", r),  data_o[0],     vecs[r].data0);
        chk($sformatf("vec%0d valid lsb", r), data_valid[0], 64'd1);
      end
      if (!vecs[r].err1) begin
        chk($sformatf("vec%0d data msb", r),  data_o[1],     vecs[r].data1);
        chk($sformatf("vec%0d valid msb", r), data_valid[1], 64'd1);
      end
      chk($sformatf("vec%0d busy after error", r), 64'(busy),
          64'({~vecs[r].err1, ~vecs[r].err0}));
      data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
    end

    // Consumer stalls for five cycles while extra symbols are offered.
    start = 1'b1; length = 7'd32;
    tick();
    start = 1'b0;
    feed(64'hDDCC_BBAA, 4);
    for (int i = 0; i < 5; i++) begin
      sym_valid = 1'b1;
      sym       = 8'($urandom);
      tick();
      chk("stall data lsb", data_o[0], 64'h0000_0000_DDCC_BBAA);
      chk("stall data msb", data_o[1], 64'h0000_0000_AABB_CCDD);
      chk("stall sym_ready", 64'(sym_ready), 64'd0);
    end
    sym_valid  = 1'b0;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    chk("stall released busy", 64'(busy), 64'd0);
    chk("stall keeps data", data_o[0], 64'h0000_0000_DDCC_BBAA);

    // Abort after three of eight bytes, together with a valid symbol.
    start = 1'b1; length = 7'd64;
    tick();
    start = 1'b0;
    feed(64'h0000_0000_0033_2211, 3);
    abort = 1'b1; sym_valid = 1'b1; sym = 8'h44;
    tick();
    abort = 1'b0; sym_valid = 1'b0;
    chk("abort busy",  64'(busy), 64'd0);
    chk("abort data",  data_o[0], 64'd0);
    chk("abort valid", 64'(data_valid), 64'd0);
    start = 1'b1; length = 7'd16;
    tick();
    start = 1'b0;
    feed(64'h3412, 2);
    chk("post-abort data lsb", data_o[0], 64'h3412);
    chk("post-abort data msb", data_o[1], 64'h1234);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;

    // Asynchronous reset in the middle of a frame.
    start = 1'b1; length = 7'd64;
    tick();
    start = 1'b0;
    feed(64'h0000_0000_0000_BBAA, 2);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("async reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       length = 7'($urandom_range(0, 127));
        1:       length = 7'($urandom_range(1, 64));
        default: length = 7'(8 * $urandom_range(1, 8));
      endcase
      abort      = ($urandom_range(0, 19) == 0);
      sym_valid  = 1'($urandom);
      sym        = 8'($urandom);
      data_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    start = 1'b0; abort = 1'b0; sym_valid = 1'b0; data_ready = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
